// File: rtl/proc_pkg.sv
// Shared definitions for the processor run controller: FSM state encoding and
// default timing values.
package proc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_state_t;

  localparam int unsigned PROC_RST_HOLD  = 4;
  localparam int unsigned PROC_DEF_LIMIT = 90;
  localparam int unsigned HOLD_CNT_W     = 4;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating up-counter of elapsed RUN cycles with synchronous clear, count
// enable and a freeze input that suppresses the increment on the exit edge.
module run_cycle_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             freeze,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !freeze && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller: holds cores in reset for RST_HOLD cycles after start, then
// runs them until every core halts, the cycle limit is reached, or abort.
module proc_run_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned N_CORES   = 1,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned RST_HOLD  = PROC_RST_HOLD,
  parameter int unsigned DEF_LIMIT = PROC_DEF_LIMIT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               limit_we,
  input  logic [CNT_W-1:0]   limit_in,
  input  logic [N_CORES-1:0] halt,
  output logic [N_CORES-1:0] core_rst_n,
  output logic               running,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycles,
  output logic [N_CORES-1:0] halt_mask
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(RST_HOLD - 1);

  run_state_t              state;
  run_state_t              state_nxt;
  logic [HOLD_CNT_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]        limit_q;
  logic [N_CORES-1:0]      mask_nxt;
  logic                    start_ok;
  logic                    all_halted;
  logic                    at_limit;

  always_comb begin
    start_ok   = start && (state inside {ST_IDLE, ST_DONE, ST_TIMEOUT});
    mask_nxt   = halt_mask | halt;
    all_halted = &mask_nxt;
    // >= rather than == so a limit lowered below the running count still ends the run
    at_limit   = (cycles >= limit_q);
    state_nxt  = state;
    case (state)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (abort)                       state_nxt = ST_TIMEOUT;
        else if (hold_cnt == HOLD_LAST)  state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort)           state_nxt = ST_TIMEOUT;
        else if (all_halted) state_nxt = ST_DONE;
        else if (at_limit)   state_nxt = ST_TIMEOUT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      halt_mask  <= '0;
      limit_q    <= CNT_W'(DEF_LIMIT);
      core_rst_n <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (limit_we) limit_q <= limit_in;
      if (start_ok) begin
        hold_cnt  <= '0;
        halt_mask <= '0;
      end else begin
        if (state == ST_HOLD) hold_cnt  <= hold_cnt + HOLD_CNT_W'(1);
        if (state == ST_RUN)  halt_mask <= mask_nxt;
      end
      // Outputs decode the next state so they line up with the state register
      running    <= (state_nxt == ST_RUN);
      done       <= (state_nxt == ST_DONE);
      timeout    <= (state_nxt == ST_TIMEOUT);
      core_rst_n <= (state_nxt inside {ST_RUN, ST_DONE, ST_TIMEOUT}) ? '1 : '0;
    end
  end

  run_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cycles (
    .clock  (clock),
    .reset  (reset),
    .clr    (start_ok),
    .en     (state == ST_RUN),
    .freeze (state_nxt != ST_RUN),
    .count  (cycles)
  );

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Scoreboard bench for proc_run_ctrl: each run pushes its expected end result
// and the completion handler pops and compares it.
module tb_proc_run_ctrl;

  localparam int NC = 2;
  localparam int CW = 16;
  localparam int RH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          limit_we = 1'b0;
  logic [CW-1:0] limit_in = '0;
  logic [NC-1:0] halt = '0;
  logic [NC-1:0] core_rst_n;
  logic          running;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycles;
  logic [NC-1:0] halt_mask;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycles;
    logic [NC-1:0] mask;
  } exp_t;

  exp_t sb[$];

  proc_run_ctrl #(
    .N_CORES   (NC),
    .CNT_W     (CW),
    .RST_HOLD  (RH),
    .DEF_LIMIT (90)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .limit_we   (limit_we),
    .limit_in   (limit_in),
    .halt       (halt),
    .core_rst_n (core_rst_n),
    .running    (running),
    .done       (done),
    .timeout    (timeout),
    .cycles     (cycles),
    .halt_mask  (halt_mask)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic d, input logic t, input int cyc, input logic [NC-1:0] m);
    exp_t e;
    e.done    = d;
    e.timeout = t;
    e.cycles  = CW'(cyc);
    e.mask    = m;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({running, done, timeout, core_rst_n, halt_mask, cycles} !== '0) begin
      failures++;
      $display("FAIL %s: run=%0b done=%0b to=%0b crst=%b mask=%b cyc=%0d, required all zero",
               name, running, done, timeout, core_rst_n, halt_mask, cycles);
    end
  endtask

  // Start a run from IDLE/DONE/TIMEOUT and step to the first RUN cycle.
  task automatic go_run(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < RH; i++) begin
      checks++;
      if (core_rst_n !== '0 || running !== 1'b0 || halt_mask !== '0 || cycles !== '0) begin
        failures++;
        $display("FAIL %s hold%0d: crst=%b run=%0b mask=%b cyc=%0d, required crst=0 run=0 mask=0 cyc=0",
                 name, i, core_rst_n, running, halt_mask, cycles);
      end
      tick();
    end
    checks++;
    if (running !== 1'b1 || core_rst_n !== '1 || cycles !== '0 || done !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL %s run_entry: run=%0b crst=%b cyc=%0d done=%0b to=%0b, required run=1 crst=11 cyc=0",
               name, running, core_rst_n, cycles, done, timeout);
    end
  endtask

  task automatic check_cycles(input string name, input int cyc);
    checks++;
    if (running !== 1'b1 || cycles !== CW'(cyc)) begin
      failures++;
      $display("FAIL %s: run=%0b cyc=%0d, required run=1 cyc=%0d", name, running, cycles, cyc);
    end
  endtask

  // Completion handler: wait (bounded) for done/timeout, then pop and compare.
  task automatic wait_end(input string name);
    int   n;
    exp_t e;
    exp_t got;
    n = 0;
    while (!(done || timeout) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (!(done || timeout)) begin
      failures++;
      $display("FAIL %s end_wait: no done/timeout after %0d cycles, required completion", name, n);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard: queue empty, required one entry", name);
      return;
    end
    e   = sb.pop_front();
    got = {done, timeout, cycles, halt_mask};
    if (got !== e) begin
      failures++;
      $display("FAIL %s result: done=%0b to=%0b cyc=%0d mask=%b, required done=%0b to=%0b cyc=%0d mask=%b",
               name, got.done, got.timeout, got.cycles, got.mask, e.done, e.timeout, e.cycles, e.mask);
    end
    checks++;
    if (running !== 1'b0 || core_rst_n !== '1) begin
      failures++;
      $display("FAIL %s end_outputs: run=%0b crst=%b, required run=0 crst=11", name, running, core_rst_n);
    end
  endtask

  task automatic test_reset();
    #2;
    check_all_zero("reset_async");
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick();
    check_all_zero("reset_release");
    tick();
    check_all_zero("idle_wait");
  endtask

  task automatic test_hold_and_count();
    go_run("hold_count");
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_cycles("count_step", k);
    end
    halt = '1;
    push_exp(1'b1, 1'b0, 3, 2'b11);
    tick();
    halt = '0;
    wait_end("hold_count");
  endtask

  task automatic test_two_core_done();
    go_run("two_core");
    repeat (10) tick();
    check_cycles("two_core_c10", 10);
    halt = 2'b01;
    tick();
    halt = '0;
    checks++;
    if (halt_mask !== 2'b01 || running !== 1'b1 || cycles !== CW'(11)) begin
      failures++;
      $display("FAIL two_core_mask01: mask=%b run=%0b cyc=%0d, required mask=01 run=1 cyc=11",
               halt_mask, running, cycles);
    end
    repeat (14) tick();
    check_cycles("two_core_c25", 25);
    halt = 2'b10;
    push_exp(1'b1, 1'b0, 25, 2'b11);
    tick();
    halt = '0;
    wait_end("two_core");
    repeat (3) tick();
    checks++;
    if (cycles !== CW'(25) || done !== 1'b1 || halt_mask !== 2'b11) begin
      failures++;
      $display("FAIL two_core_frozen: cyc=%0d done=%0b mask=%b, required cyc=25 done=1 mask=11",
               cycles, done, halt_mask);
    end
  endtask

  task automatic test_start_ignored();
    go_run("restart");
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_cycles("start_in_run_c4", 4);
    tick();
    check_cycles("start_in_run_c5", 5);
    halt = '1;
    push_exp(1'b1, 1'b0, 5, 2'b11);
    tick();
    halt = '0;
    wait_end("restart");
  endtask

  task automatic test_timeout();
    limit_we = 1'b1;
    limit_in = CW'(20);
    tick();
    limit_we = 1'b0;
    checks++;
    if (done !== 1'b1 || running !== 1'b0) begin
      failures++;
      $display("FAIL limit_write_in_done: done=%0b run=%0b, required done=1 run=0", done, running);
    end
    go_run("timeout20");
    push_exp(1'b0, 1'b1, 20, 2'b00);
    wait_end("timeout20");
  endtask

  task automatic test_done_at_limit();
    go_run("done_at_limit");
    repeat (20) tick();
    check_cycles("limit_c20", 20);
    halt = '1;
    push_exp(1'b1, 1'b0, 20, 2'b11);
    tick();
    halt = '0;
    wait_end("done_at_limit");
  endtask

  task automatic test_abort();
    go_run("abort_run");
    repeat (5) tick();
    abort = 1'b1;
    push_exp(1'b0, 1'b1, 5, 2'b00);
    tick();
    abort = 1'b0;
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL abort_run_latency: to=%0b, required 1 one cycle after abort", timeout);
    end
    wait_end("abort_run");
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    push_exp(1'b0, 1'b1, 0, 2'b00);
    tick();
    abort = 1'b0;
    checks++;
    if (timeout !== 1'b1 || core_rst_n !== '1) begin
      failures++;
      $display("FAIL abort_hold: to=%0b crst=%b, required to=1 crst=11", timeout, core_rst_n);
    end
    wait_end("abort_hold");
  endtask

  task automatic test_limit_zero();
    go_run("limit_zero");
    repeat (5) tick();
    limit_we = 1'b1;
    limit_in = '0;
    tick();
    limit_we = 1'b0;
    check_cycles("limit_zero_c6", 6);
    push_exp(1'b0, 1'b1, 6, 2'b00);
    tick();
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL limit_zero_latency: to=%0b, required 1", timeout);
    end
    wait_end("limit_zero");
  endtask

  task automatic test_reset_mid_run();
    go_run("mid_reset");
    repeat (7) tick();
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset_async");
    start = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("start_in_reset");
    start = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    tick();
    check_all_zero("idle_after_reset");
    go_run("default_limit");
    push_exp(1'b0, 1'b1, 90, 2'b00);
    wait_end("default_limit");
  endtask

  initial begin
    test_reset();
    test_hold_and_count();
    test_two_core_done();
    test_start_ignored();
    test_timeout();
    test_done_at_limit();
    test_abort();
    test_limit_zero();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
